// File: rtl/ws2812_frame_sched_if.sv
// PIO control port shared by the WS2812 frame scheduler (master) and the PIO block (slave).
// The scheduler drives the action/data/index lines and observes the per-machine TX FIFO full flags.
interface ws2812_frame_sched_if;
    logic [3:0]  action;
    logic [31:0] din;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [3:0]  full;

    modport master (output action, din, index, mindex, input full);
    modport slave  (input action, din, index, mindex, output full);
endinterface

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: loads the PIO program and configuration from ROMs, then streams
// GRB pixel frames into one state machine's TX FIFO with a latch gap after each frame.
module ws2812_frame_sched #(
    parameter int PROG_LEN     = 32,
    parameter int CONF_LEN     = 6,
    parameter int NUM_PIX      = 16,
    parameter int LATCH_CYCLES = 5000,
    parameter int MACHINE      = 0
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [4:0]  conf_addr,
    input  logic [35:0] conf_data,
    output logic [7:0]  pix_addr,
    input  logic [23:0] pix_data,
    input  logic        frame_req,
    ws2812_frame_sched_if.master pio,
    output logic        cfg_done,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [7:0]  stall_cnt
);
    localparam logic [4:0]  PROG_LAST  = 5'(PROG_LEN - 1);
    localparam logic [4:0]  CONF_LAST  = 5'((CONF_LEN == 0) ? 0 : CONF_LEN - 1);
    localparam logic [7:0]  PIX_LAST   = 8'(NUM_PIX - 1);
    localparam logic [15:0] LATCH_LOAD = 16'(LATCH_CYCLES - 1);

    localparam logic [3:0] ACT_NONE = 4'd0;
    localparam logic [3:0] ACT_LOAD = 4'd1;
    localparam logic [3:0] ACT_PUSH = 4'd4;

    typedef enum logic [2:0] {
        LOAD_PROG,
        LOAD_CONF,
        CFG_END,
        IDLE,
        PUSH,
        GAP,
        LATCH
    } state_t;

    state_t      state, state_n;
    logic [4:0]  prog_addr_n, conf_addr_n, index_q, index_n;
    logic [7:0]  pix_addr_n, stall_n;
    logic [15:0] latch_cnt, latch_cnt_n;
    logic [3:0]  action_q, action_n;
    logic [31:0] din_q, din_n;
    logic        cfg_done_n, frame_busy_n, frame_done_n;
    logic        machine_full;
    logic        unused_full;

    assign machine_full = pio.full[MACHINE];
    assign unused_full  = ^pio.full;

    assign pio.action = action_q;
    assign pio.din    = din_q;
    assign pio.index  = index_q;
    assign pio.mindex = 2'(MACHINE);

    // Every output is the registered result of the decision taken in the current state,
    // so each ROM/pixel read lands in din one cycle after its address is presented.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state      <= LOAD_PROG;
            prog_addr  <= '0;
            conf_addr  <= '0;
            pix_addr   <= '0;
            latch_cnt  <= '0;
            action_q   <= ACT_NONE;
            din_q      <= '0;
            index_q    <= '0;
            cfg_done   <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_n;
            prog_addr  <= prog_addr_n;
            conf_addr  <= conf_addr_n;
            pix_addr   <= pix_addr_n;
            latch_cnt  <= latch_cnt_n;
            action_q   <= action_n;
            din_q      <= din_n;
            index_q    <= index_n;
            cfg_done   <= cfg_done_n;
            frame_busy <= frame_busy_n;
            frame_done <= frame_done_n;
            stall_cnt  <= stall_n;
        end
    end

    always_comb begin
        state_n      = state;
        prog_addr_n  = prog_addr;
        conf_addr_n  = conf_addr;
        pix_addr_n   = pix_addr;
        latch_cnt_n  = latch_cnt;
        action_n     = ACT_NONE;
        din_n        = din_q;
        index_n      = index_q;
        cfg_done_n   = cfg_done;
        frame_busy_n = frame_busy;
        frame_done_n = 1'b0;
        stall_n      = stall_cnt;

        case (state)
            LOAD_PROG: begin
                action_n = ACT_LOAD;
                index_n  = prog_addr;
                din_n    = {16'h0000, prog_data};
                if (prog_addr == PROG_LAST) begin
                    state_n = (CONF_LEN == 0) ? CFG_END : LOAD_CONF;
                end else begin
                    prog_addr_n = prog_addr + 5'd1;
                end
            end
            LOAD_CONF: begin
                action_n = conf_data[35:32];
                din_n    = conf_data[31:0];
                if (conf_addr == CONF_LAST) begin
                    state_n = CFG_END;
                end else begin
                    conf_addr_n = conf_addr + 5'd1;
                end
            end
            CFG_END: begin
                cfg_done_n = 1'b1;
                state_n    = IDLE;
            end
            IDLE: begin
                if (frame_req) begin
                    pix_addr_n   = '0;
                    frame_busy_n = 1'b1;
                    state_n      = PUSH;
                end
            end
            PUSH: begin
                // Pixel is MSB-aligned because the PIO program shifts OUT to the left.
                if (!machine_full) begin
                    action_n = ACT_PUSH;
                    din_n    = {pix_data, 8'h00};
                    state_n  = GAP;
                end else if (stall_cnt != 8'hFF) begin
                    stall_n = stall_cnt + 8'd1;
                end
            end
            GAP: begin
                if (pix_addr == PIX_LAST) begin
                    latch_cnt_n = LATCH_LOAD;
                    state_n     = LATCH;
                end else begin
                    pix_addr_n = pix_addr + 8'd1;
                    state_n    = PUSH;
                end
            end
            LATCH: begin
                if (latch_cnt == 16'd0) begin
                    frame_done_n = 1'b1;
                    frame_busy_n = 1'b0;
                    state_n      = IDLE;
                end else begin
                    latch_cnt_n = latch_cnt - 16'd1;
                end
            end
            default: state_n = LOAD_PROG;
        endcase
    end
endmodule

// File: doc/ws2812_frame_sched.md
# ws2812_frame_sched

Sequencer that owns the PIO control port (`action`/`din`/`index`/`mindex`) for WS2812 strips. After reset it loads the PIO program and state-machine configuration from external ROMs. It then streams one frame of `NUM_PIX` GRB pixels from a frame buffer into the TX FIFO of one state machine, with backpressure from that FIFO's `full` flag. It inserts a latch gap between frames and reports completion and stall statistics to the top level.

## Interface
Parameters:
- `PROG_LEN`, 32: instruction words loaded (1..32).
- `CONF_LEN`, 6: configuration words loaded (0..32).
- `NUM_PIX`, 16: pixels per frame (1..256).
- `LATCH_CYCLES`, 5000: idle cycles after the last push before `frame_done`. This covers the FIFO drain plus ≥50 µs of WS2812 reset.
- `MACHINE`, 0: PIO state machine index (0..3).

Ports:
- `clk_25mhz` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `prog_addr` out 5: program ROM address. The ROM read is combinational, so data is valid in the same cycle.
- `prog_data` in 16: program ROM word.
- `conf_addr` out 5: configuration ROM address (combinational read).
- `conf_data` in 36: bits [35:32] are the action, bits [31:0] are the data.
- `pix_addr` out 8: frame buffer address (combinational read).
- `pix_data` in 24: GRB pixel.
- `frame_req` in 1: level-sensitive request to send a frame.
- `full` in 4: PIO TX FIFO full flags.
- `action` out 4: PIO action. 0 = none, 1 = load instruction, 4 = push, others come from the configuration ROM.
- `din` out 32: PIO data.
- `index` out 5: instruction index.
- `mindex` out 2: machine index. Constant `MACHINE`.
- `cfg_done` out 1: high once program and configuration loading is complete.
- `frame_busy` out 1: high from frame acceptance until `frame_done`.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `stall_cnt` out 8: saturating count of PUSH-state cycles with `full[MACHINE]` high.

## Operation
- All outputs are registered.
- Reset values: `action`=0, `din`=0, `index`=0, `mindex`=`MACHINE`, `cfg_done`=0, `frame_busy`=0, `frame_done`=0, `stall_cnt`=0, all addresses 0.
- A reset asserted in any state aborts the current operation and restarts at `LOAD_PROG`. Pixels already in the FIFO are not recalled.

States:
- **LOAD_PROG**
  - For i = 0..`PROG_LEN`-1, one word per cycle: `action`=1, `index`=i, `din`={16'h0, `prog_data`} with `prog_addr`=i.
  - After word `PROG_LEN`-1, go to LOAD_CONF. If `CONF_LEN`=0, go to CFG_END.
- **LOAD_CONF**
  - For j = 0..`CONF_LEN`-1: `action`=`conf_data[35:32]`, `din`=`conf_data[31:0]` with `conf_addr`=j.
  - Then go to CFG_END.
- **CFG_END**
  - One cycle with `action`=0; set `cfg_done`=1, which stays high until reset.
  - Then go to IDLE.
- **IDLE**
  - `action`=0.
  - If `frame_req`=1: set `pix_addr`=0, `frame_busy`=1, go to PUSH.
- **PUSH**
  - If `full[MACHINE]`=0: `action`=4, `din`={`pix_data`, 8'h00} (pixel MSB-aligned for a left-shifting OUT), then go to GAP.
  - Otherwise `action`=0, increment `stall_cnt` (saturating at 255), stay in PUSH.
- **GAP**
  - One cycle with `action`=0. This guarantees each push is a single-cycle pulse and that the updated `full` flag is visible before the next push.
  - If `pix_addr`=`NUM_PIX`-1: go to LATCH and load the counter with `LATCH_CYCLES`-1.
  - Otherwise increment `pix_addr` and go to PUSH.
- **LATCH**
  - `action`=0; decrement the counter.
  - At 0: pulse `frame_done` for one cycle, clear `frame_busy`, go to IDLE.

Other rules:
- `frame_req` is ignored outside IDLE.
- If `frame_req` is still high when IDLE is re-entered, the next frame starts immediately.
- `din` holds its last value whenever `action`=0.
- The latch counter is 16 bits wide; `LATCH_CYCLES` must be ≥1.

## Timing
- The first load action is on the first cycle after reset deasserts. Configuration loading starts in cycle `PROG_LEN`.
- `cfg_done` rises `PROG_LEN`+`CONF_LEN`+1 cycles after reset release.
- `frame_req`→first push: 1 cycle after IDLE samples the request (IDLE→PUSH, push issued in PUSH), provided the FIFO is not full.
- Pushes are at most one every 2 cycles.
- Unstalled frame, from request sampled to `frame_done`: 1 + 2·`NUM_PIX` + `LATCH_CYCLES` cycles.
- A stall adds exactly one cycle per `full`-high cycle. The push occurs in the first PUSH cycle where `full`=0.
- Only `full[MACHINE]` is observed; the other bits of `full` are ignored.

## Test plan
- Reset release with a ROM pattern (`prog[i]`=16'hA000+i) → 32 consecutive cycles with `action`=1 and `index`=0..31, `din`=0000A000..0000A01F. Then 6 configuration words with their action codes. Then `cfg_done`=1 at cycle 39.
- `frame_req` high for one cycle, `full`=0, `NUM_PIX`=16 → exactly 16 single-cycle `action`=4 pulses, 2 cycles apart. `din` for pixel 3 (24'h00FF00) is 32'h00FF0000. `frame_done` pulses once, 5033 cycles after the request. `stall_cnt`=0.
- Hold `full[MACHINE]` high for 10 cycles during pixel 5 → no push while `full` is high, `stall_cnt`=10. Pixel 5 is pushed once, on the cycle `full` drops. Frame is 10 cycles longer.
- `full` bits other than `MACHINE` held high → no effect on pushes.
- `frame_req` held high continuously → back-to-back frames. `frame_done` pulses are separated by 5033 cycles, and `pix_addr` restarts at 0.
- Assert `reset` mid-frame at pixel 7 → outputs return to reset values the next cycle, and the program reload restarts at `index`=0.
